// File: rtl/collision_pkg.sv
// Shared types for the collision checker: object descriptor layout and scan FSM states.
// Pure declarations, no logic; COLLISION_OVERLAP_EN does not change anything here.
package collision_pkg;
   localparam int COORD_W = 11;
   localparam int OBJ_W   = 4 * COORD_W;

   typedef struct packed {
      logic [COORD_W-1:0] left_x;
      logic [COORD_W-1:0] top_y;
      logic [COORD_W-1:0] right_x;
      logic [COORD_W-1:0] bottom_y;
   } obj_t;

   typedef struct packed {
      logic up;
      logic down;
      logic left;
      logic right;
   } hits_t;

   typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;
endpackage

// File: rtl/collision_cmp.sv
// Combinational side-hit test of one object against the player box; zero latency, no flow control.
// COLLISION_OVERLAP_EN adds the o_overlap (box intersection) output.
module collision_cmp
   import collision_pkg::*;
#(
   parameter int PLAYER_W = 16,
   parameter int PLAYER_H = 16
) (
   input  obj_t        i_obj,
   input  logic [9:0]  i_x,
   input  logic [8:0]  i_y,
`ifdef COLLISION_OVERLAP_EN
   output logic        o_overlap,
`endif
   output hits_t       o_hits
);
   // All arithmetic is 12-bit and additive only, so x=0 / y=0 cannot wrap.
   logic [11:0] w_x, w_y, w_x_last, w_y_last, w_x_next, w_y_next;
   logic [11:0] w_lx, w_ty, w_rx, w_by;
   logic        w_h, w_v;

   assign w_x      = {2'b00, i_x};
   assign w_y      = {3'b000, i_y};
   assign w_x_last = w_x + 12'(PLAYER_W - 1);
   assign w_y_last = w_y + 12'(PLAYER_H - 1);
   assign w_x_next = w_x + 12'(PLAYER_W);
   assign w_y_next = w_y + 12'(PLAYER_H);
   assign w_lx     = {1'b0, i_obj.left_x};
   assign w_ty     = {1'b0, i_obj.top_y};
   assign w_rx     = {1'b0, i_obj.right_x};
   assign w_by     = {1'b0, i_obj.bottom_y};

   assign w_h = (w_lx <= w_x_last) && (w_rx >= w_x);
   assign w_v = (w_ty <= w_y_last) && (w_by >= w_y);

   assign o_hits.down  = w_h && (w_ty == w_y_next);
   assign o_hits.up    = w_h && ((w_by + 12'd1) == w_y);
   assign o_hits.right = w_v && (w_lx == w_x_next);
   assign o_hits.left  = w_v && ((w_rx + 12'd1) == w_x);
`ifdef COLLISION_OVERLAP_EN
   assign o_overlap    = w_h && w_v;
`endif
endmodule

// File: rtl/collision.sv
// Sequential collision scan, one object per clock; done pulses object_num+2 edges after start, no backpressure.
// COLLISION_OVERLAP_EN adds the overlap output and lets intersecting objects qualify as collided_object.
module collision
   import collision_pkg::*;
#(
   parameter int object_num = 2,
   parameter int PLAYER_W   = 16,
   parameter int PLAYER_H   = 16
) (
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic                        start,
   input  logic                        redo,
   input  logic [9:0]                  x,
   input  logic [8:0]                  y,
   input  logic [object_num-1:0][43:0] objects,
   output logic                        up,
   output logic                        down,
   output logic                        left,
   output logic                        right,
   output logic                        done,
`ifdef COLLISION_OVERLAP_EN
   output logic                        overlap,
`endif
   output logic [43:0]                 collided_object
);
   localparam int IDX_W = (object_num > 1) ? $clog2(object_num) : 1;

   state_t                      r_state;
   logic [IDX_W-1:0]            r_idx;
   logic [9:0]                  r_x;
   logic [8:0]                  r_y;
   logic [object_num-1:0][43:0] r_objs;
   hits_t                       r_acc;
   logic                        r_found;
   obj_t                        r_cand;

   obj_t                        w_obj;
   hits_t                       w_hits;
   logic                        w_any;
   logic                        w_last;
   logic                        w_capture;

   assign w_obj  = obj_t'(r_objs[r_idx]);
   assign w_last = (r_idx == IDX_W'(object_num - 1));
   assign w_capture = ((r_state == IDLE) && start) ||
                      ((r_state == DONE) && (redo || start));

`ifdef COLLISION_OVERLAP_EN
   logic w_ovl;
   logic r_acc_ovl;

   collision_cmp #(.PLAYER_W(PLAYER_W), .PLAYER_H(PLAYER_H)) u_cmp (
      .i_obj     (w_obj),
      .i_x       (r_x),
      .i_y       (r_y),
      .o_overlap (w_ovl),
      .o_hits    (w_hits)
   );
   assign w_any = (|w_hits) || w_ovl;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_acc_ovl <= 1'b0;
         overlap   <= 1'b0;
      end else begin
         if (w_capture)
            r_acc_ovl <= 1'b0;
         else if (r_state == SCAN)
            r_acc_ovl <= r_acc_ovl | w_ovl;
         if (r_state == DONE)
            overlap <= r_acc_ovl;
      end
   end
`else
   collision_cmp #(.PLAYER_W(PLAYER_W), .PLAYER_H(PLAYER_H)) u_cmp (
      .i_obj  (w_obj),
      .i_x    (r_x),
      .i_y    (r_y),
      .o_hits (w_hits)
   );
   assign w_any = |w_hits;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state         <= IDLE;
         r_idx           <= '0;
         r_x             <= '0;
         r_y             <= '0;
         r_objs          <= '0;
         r_acc           <= '0;
         r_found         <= 1'b0;
         r_cand          <= '0;
         up              <= 1'b0;
         down            <= 1'b0;
         left            <= 1'b0;
         right           <= 1'b0;
         done            <= 1'b0;
         collided_object <= '0;
      end else begin
         done <= 1'b0;
         case (r_state)
            IDLE: if (start) r_state <= SCAN;
            SCAN: begin
               r_acc <= hits_t'(r_acc | w_hits);
               // First hit wins; later objects only contribute flags.
               if (w_any && !r_found) begin
                  r_found <= 1'b1;
                  r_cand  <= w_obj;
               end
               if (w_last) begin
                  r_state <= DONE;
                  r_idx   <= '0;
               end else begin
                  r_idx   <= r_idx + IDX_W'(1);
               end
            end
            DONE: begin
               up              <= r_acc.up;
               down            <= r_acc.down;
               left            <= r_acc.left;
               right           <= r_acc.right;
               collided_object <= r_found ? r_cand : '0;
               done            <= 1'b1;
               r_state         <= (redo || start) ? SCAN : IDLE;
            end
            default: r_state <= IDLE;
         endcase
         // Fresh scan: snapshot inputs so mid-scan changes only affect the next scan.
         if (w_capture) begin
            r_x     <= x;
            r_y     <= y;
            r_objs  <= objects;
            r_idx   <= '0;
            r_acc   <= '0;
            r_found <= 1'b0;
            r_cand  <= '0;
         end
      end
   end
endmodule

// File: tb/tb_collision.sv
// Directed scoreboard bench for collision: expected results from a behavioural model, checked at each done.
module tb_collision;
   import collision_pkg::*;

   localparam int N  = 2;
   localparam int PW = 16;
   localparam int PH = 16;
   localparam logic [43:0] OBJ0 = {11'd20, 11'd20, 11'd40, 11'd25};
   localparam logic [43:0] OBJ1 = {11'd20, 11'd50, 11'd40, 11'd55};

   logic               clk = 1'b0;
   logic               rst_n = 1'b0;
   logic               start = 1'b0;
   logic               redo = 1'b0;
   logic [9:0]         x = '0;
   logic [8:0]         y = '0;
   logic [N-1:0][43:0] objects;
   logic               up, down, left, right, done;
   logic [43:0]        collided_object;
   logic               ovl_obs;

   typedef struct packed {
      logic        up;
      logic        down;
      logic        left;
      logic        right;
      logic        ovl;
      logic [43:0] coll;
   } exp_t;

   exp_t sb[$];
   int   checks = 0;
   int   errors = 0;

   always #5 clk = ~clk;

`ifdef COLLISION_OVERLAP_EN
   logic overlap;
   assign ovl_obs = overlap;
   collision #(.object_num(N), .PLAYER_W(PW), .PLAYER_H(PH)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .redo(redo), .x(x), .y(y),
      .objects(objects), .up(up), .down(down), .left(left), .right(right),
      .done(done), .overlap(overlap), .collided_object(collided_object)
   );
`else
   assign ovl_obs = 1'b0;
   collision #(.object_num(N), .PLAYER_W(PW), .PLAYER_H(PH)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .redo(redo), .x(x), .y(y),
      .objects(objects), .up(up), .down(down), .left(left), .right(right),
      .done(done), .collided_object(collided_object)
   );
`endif

   function automatic exp_t model(input logic [9:0] px, input logic [8:0] py,
                                  input logic [N-1:0][43:0] ob);
      exp_t e;
      bit   found;
      e = '0;
      found = 0;
      for (int i = 0; i < N; i++) begin
         int lx, ty, rx, by, xl, yt;
         bit h, v, d, u, r, l, o, any;
         lx = int'(ob[i][43:33]);
         ty = int'(ob[i][32:22]);
         rx = int'(ob[i][21:11]);
         by = int'(ob[i][10:0]);
         xl = int'(px);
         yt = int'(py);
         h = (lx <= xl + PW - 1) && (rx >= xl);
         v = (ty <= yt + PH - 1) && (by >= yt);
         d = h && (ty == yt + PH);
         u = h && (by + 1 == yt);
         r = v && (lx == xl + PW);
         l = v && (rx + 1 == xl);
         o = h && v;
         any = d || u || r || l;
`ifdef COLLISION_OVERLAP_EN
         any = any || o;
         e.ovl = e.ovl | o;
`endif
         e.down  = e.down | d;
         e.up    = e.up | u;
         e.right = e.right | r;
         e.left  = e.left | l;
         if (any && !found) begin
            found  = 1;
            e.coll = ob[i];
         end
      end
      return e;
   endfunction

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_done(input string tag, output int n);
      n = 0;
      do begin
         tick();
         n++;
      end while (!done && n < 20);
      chk({tag, "_timeout"}, 64'(done), 64'd1);
   endtask

   task automatic check_out(input string tag);
      exp_t e;
      if (sb.size() == 0) begin
         chk({tag, "_sb_empty"}, 64'd0, 64'd1);
         return;
      end
      e = sb.pop_front();
      chk({tag, "_up"},    64'(up),              64'(e.up));
      chk({tag, "_down"},  64'(down),            64'(e.down));
      chk({tag, "_left"},  64'(left),            64'(e.left));
      chk({tag, "_right"}, 64'(right),           64'(e.right));
      chk({tag, "_ovl"},   64'(ovl_obs),         64'(e.ovl));
      chk({tag, "_coll"},  64'(collided_object), 64'(e.coll));
   endtask

   task automatic run_scan(input string tag, input int px, input int py);
      int n;
      x = 10'(px);
      y = 9'(py);
      start = 1'b1;
      sb.push_back(model(x, y, objects));
      tick();
      start = 1'b0;
      // Mid-scan input changes must not leak into this result.
      x = 10'd300;
      y = 9'd300;
      wait_done(tag, n);
      chk({tag, "_latency"}, 64'(n), 64'd3);
      check_out(tag);
      tick();
      chk({tag, "_pulse"}, 64'(done), 64'd0);
   endtask

   initial begin
      int n;
      bit saw_done;
      objects[0] = OBJ0;
      objects[1] = OBJ1;

      repeat (2) tick();
      chk("rst_up",   64'(up),              64'd0);
      chk("rst_down", 64'(down),            64'd0);
      chk("rst_left", 64'(left),            64'd0);
      chk("rst_right",64'(right),           64'd0);
      chk("rst_done", 64'(done),            64'd0);
      chk("rst_coll", 64'(collided_object), 64'd0);
      rst_n = 1'b1;
      tick();

      run_scan("down", 10, 4);
      chk("down_only", 64'({up, down, left, right}), 64'b0100);
      chk("down_coll", 64'(collided_object), 64'(OBJ0));
      run_scan("right", 4, 15);
      chk("right_only", 64'({up, down, left, right}), 64'b0001);
      chk("right_coll", 64'(collided_object), 64'(OBJ0));
      run_scan("left", 41, 15);
      chk("left_only", 64'({up, down, left, right}), 64'b0010);
      run_scan("up", 20, 26);
      chk("up_only", 64'({up, down, left, right}), 64'b1000);
      chk("up_coll", 64'(collided_object), 64'(OBJ0));
      run_scan("origin", 0, 0);
      chk("origin_flags", 64'({up, down, left, right}), 64'b0000);
      chk("origin_coll", 64'(collided_object), 64'd0);

      // Continuous mode sweep: y stepped by one per scan.
      x = 10'd40;
      y = 9'd0;
      redo = 1'b1;
      start = 1'b1;
      sb.push_back(model(x, y, objects));
      tick();
      start = 1'b0;
      y = 9'd1;
      for (int s = 0; s < 40; s++) begin
         wait_done("sweep", n);
         chk("sweep_period", 64'(n), 64'd3);
         check_out("sweep");
         if (s == 4)  chk("sweep_down_rise", 64'(down), 64'd1);
         if (s == 5)  chk("sweep_down_clear", 64'(down), 64'd0);
         if (s == 34) begin
            chk("sweep_obj1_down", 64'(down), 64'd1);
            chk("sweep_obj1_coll", 64'(collided_object), 64'(OBJ1));
         end
         if (s < 39) begin
            sb.push_back(model(x, 9'(s + 1), objects));
            y = 9'(s + 2);
         end
         if (s == 38) redo = 1'b0;
      end
      tick();
      chk("sweep_end_pulse", 64'(done), 64'd0);

      // Reset in the middle of a scan.
      run_scan("pre_rst", 10, 4);
      x = 10'd20;
      y = 9'd26;
      start = 1'b1;
      tick();
      start = 1'b0;
      tick();
      #2 rst_n = 1'b0;
      #1;
      chk("mid_rst_flags", 64'({up, down, left, right}), 64'b0000);
      chk("mid_rst_done",  64'(done), 64'd0);
      chk("mid_rst_coll",  64'(collided_object), 64'd0);
      chk("mid_rst_ovl",   64'(ovl_obs), 64'd0);
      tick();
      rst_n = 1'b1;
      saw_done = 0;
      for (int k = 0; k < 8; k++) begin
         tick();
         if (done) saw_done = 1;
      end
      chk("post_rst_no_done", 64'(saw_done), 64'd0);
      run_scan("recover", 4, 15);

      chk("sb_drained", 64'(sb.size()), 64'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/collision.md
# collision

Sequential collision checker for the platformer. It compares a player bounding box at (x, y) against a parameterised list of rectangular scene objects, one object per clock. It reports which sides of the player touch an object, and which object was hit first. It sits between the object table and the player-motion logic, which uses up/down/left/right to block movement.

## Interface
- object_num, default 2: number of entries in `objects`; must be ≥ 1.
- PLAYER_W, default 16: player box width in pixels.
- PLAYER_H, default 16: player box height in pixels.
- clk  input  1  system clock; all logic on the rising edge.
- rst_n  input  1  reset; asynchronous, active-low.
- start  input  1  request one scan; level-sampled in IDLE.
- redo  input  1  continuous mode; when high, a new scan begins immediately after each completed scan.
- x  input  10  player left column.
- y  input  9  player top row.
- objects  input  [object_num-1:0][43:0]  object descriptors; each entry packs left_x[43:33], top_y[32:22], right_x[21:11], bottom_y[10:0]. All bounds are inclusive and unsigned.
- up  output  1  an object touches the player's top edge.
- down  output  1  an object touches the player's bottom edge.
- left  output  1  an object touches the player's left edge.
- right  output  1  an object touches the player's right edge.
- done  output  1  one-cycle pulse when a scan completes and the outputs are updated.
- collided_object  output  44  descriptor of the lowest-index object that set any flag; 0 if none did.

## Operation
- Player box: columns x..x+PLAYER_W-1, rows y..y+PLAYER_H-1.
- x and y are zero-extended to 12 bits for all arithmetic; there is no subtraction, so there is no underflow at x=0 or y=0.
- Overlap tests:
  - Horizontal overlap (H): left_x ≤ x+PLAYER_W-1 and right_x ≥ x.
  - Vertical overlap (V): top_y ≤ y+PLAYER_H-1 and bottom_y ≥ y.
- Per-object side hits:
  - down = H and top_y == y+PLAYER_H.
  - up = H and bottom_y+1 == y.
  - right = V and left_x == x+PLAYER_W.
  - left = V and right_x+1 == x.
- The four flags are OR-accumulated across all objects during a scan.
- The first object (lowest index) with any hit is latched as the candidate collided_object; later hits do not replace it.
- State machine:
  - IDLE: start=1 → SCAN, index cleared, accumulators cleared, x/y captured.
  - SCAN: evaluate objects[index] and increment index. After index object_num-1 → DONE.
  - DONE: copy the accumulators to the outputs and pulse done. Then go to SCAN (fresh capture and clear) if redo or start is high, otherwise IDLE.
- x, y and objects are captured at scan start; changes during a scan affect the next scan only.
- start during SCAN is ignored.
- Outputs hold their values between done pulses.

## Timing
- Reset (rst_n low, at any time, including mid-scan): state IDLE; up, down, left, right, done = 0; collided_object = 0; index = 0.
- Latency: with start sampled high at edge N, done is high for the cycle after edge N+object_num+1, and the outputs change on that same edge.
- Continuous mode: the period is object_num+1 cycles per scan. done pulses once per scan and is never high for two consecutive cycles.

## Configuration
- COLLISION_OVERLAP_EN defined: adds output `overlap` (1 bit, reset 0), set when any object intersects the player box (H and V). It is updated at done like the other flags, and an overlapping object also qualifies as collided_object.
- Not defined: no `overlap` port, and overlap does not affect collided_object.

## Structure
- Package collision_pkg: COORD_W = 11, packed struct obj_t {left_x, top_y, right_x, bottom_y}, and the state enum {IDLE, SCAN, DONE}.
- One combinational sub-module, collision_cmp: takes one obj_t plus x, y and the player dimensions, and produces the up/down/left/right (and overlap) hits. It is instantiated once and fed by the index mux.

## Test plan
Objects for all scenarios: obj0 = (20,20,40,25), obj1 = (20,50,40,55), object_num=2, 16×16 player.
- x=10, y=4, start pulse → down=1 only, collided_object = obj0, done exactly 3 cycles after start.
- x=4, y=15 → right=1 only, collided_object = obj0.
- x=41, y=15 → left=1 only. x=20, y=26 → up=1 only, collided_object = obj0.
- x=40, y=0, redo=1, y stepped +1 each scan for 40 scans → down rises at y=4 and clears at y=5; at y=34, down=1 with collided_object = obj1; done pulses every 3 cycles.
- x=0, y=0 → all flags 0, collided_object = 0, no false left/up from wraparound.
- rst_n low mid-scan → all outputs 0 immediately, IDLE; no done until the next start.
